adder_tree_acc: RTL and testbench
=================================

Name: adder_tree_acc

Overview:
- Pipelined, registered-per-level adder tree reducing NUM words of SIZE bits per beat.
- Adds full bit growth, optional signed arithmetic, a valid/last sideband pipeline, and a frame accumulator that sums successive beats into one result per frame.
- Used wherever multi-beat dot-product or reduction results are needed, e.g. downstream of multiplier arrays.

Parameters:
- SIZE, 10, input word width.
- NUM, 16, inputs per beat (>=1).
- SIGNED, 0, 1 = two's-complement operands and result; 0 = unsigned.
- ACC_SIZE, 32, accumulator/output width; must be >= SIZE+clog2(NUM), else elaboration error.
- CNT_W, 16, beat-counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- din_valid  in  1  beat qualifier.
- din_last  in  1  final beat of the frame; ignored when din_valid=0.
- din  in  SIZE x [0:NUM-1]  unpacked input words.
- dout_valid  out  1  one-cycle pulse, frame result valid.
- dout  out  ACC_SIZE  frame sum; held between pulses.
- dout_beats  out  CNT_W  number of beats in the reported frame; saturates at all-ones.
- dout_ovf  out  1  accumulator overflowed at least once during the reported frame.

Behaviour:
- Tree levels: LAT = clog2(NUM) for NUM>=2; LAT = 1 for NUM=1 (single register stage).
  - Each level pairs adjacent words and registers the sums.
  - An odd leftover word is registered unchanged.
  - Each level widens by 1 bit: sign-extend if SIGNED=1, zero-extend otherwise. No tree overflow is possible.
- Sideband: valid and last are delayed alongside the data through every level.
  - Tree data registers need no reset; sideband valid registers reset to 0.
- Accumulator stage (one cycle), on tree-output valid:
  - acc_next = (first ? 0 : acc) + ext(tree_sum), extended to ACC_SIZE.
  - acc <= acc_next.
  - beats <= (first ? 1 : beats+1), saturating at all-ones.
  - ovf <= (first ? 0 : ovf) | overflow(acc_next).
  - first <= tree_last.
- Overflow definition:
  - Unsigned: carry out of bit ACC_SIZE-1.
  - Signed: operands share a sign and the result sign differs.
  - Default behaviour: wrap modulo 2^ACC_SIZE.
- Output: on a valid beat with tree_last=1, the next edge updates dout/dout_beats/dout_ovf with the frame values and pulses dout_valid for one cycle. Outputs hold otherwise.
- Latency: input beat carrying last -> dout_valid is exactly LAT+1 cycles later.
- Throughput: one beat per cycle, no backpressure.
  - Gaps (din_valid=0) within a frame are allowed and do not reset the frame.
  - Back-to-back single-beat frames produce dout_valid on consecutive cycles.
- Reset (async assert, any time): all valids=0, first=1, acc=0, dout=0, dout_beats=0, dout_ovf=0, dout_valid=0.
  - Any frame in flight is discarded and never reported.
  - Data presented while rst=1 is ignored.
  - The first valid beat after reset release starts a new frame.

Optional Feature:
- Macro: ADDER_TREE_ACC_SAT_EN.
- Defined:
  - On overflow, the accumulator clamps to the representable extreme: unsigned all-ones; signed max positive or min negative, following the operand sign.
  - It stays clamped until a later beat moves it back in range, computed from the clamped value.
  - dout_ovf is still set.
- Undefined: wrap behaviour as above. No saturation logic is generated.

Test Plan:
- NUM=4, SIZE=8, ACC_SIZE=16, unsigned: one beat {1,2,3,4}, last=1 -> 3 cycles later dout_valid=1 for 1 cycle, dout=10, dout_beats=1, dout_ovf=0.
- Same config: 3 beats of {255,255,255,255} with a 2-cycle gap after beat 1, last on beat 3 -> dout=3060, dout_beats=3, exactly one dout_valid pulse.
- Same config, back-to-back frames {1,1,1,1} last then {2,2,2,2} last -> dout_valid on two consecutive cycles, dout=4 then 8.
- ACC_SIZE=10: two beats of all-255, last on beat 2 -> macro undefined: dout=1016, dout_ovf=1; ADDER_TREE_ACC_SAT_EN defined: dout=1023, dout_ovf=1.
- SIGNED=1, SIZE=8, ACC_SIZE=16: one beat {-128,-128,127,1}, last -> dout=16'hFF80 (-128), dout_ovf=0.
- Two non-last beats of {9,9,9,9}, then rst pulsed asynchronously mid-cycle, then {1,2,3,4} last -> no dout_valid for the discarded frame; dout=10, dout_beats=1; all outputs read 0 while rst=1.

Source files
------------

// File: rtl/adder_tree_acc.sv
`default_nettype none
// ============================================================================
// Module   : adder_tree_acc
// Brief    : Pipelined adder tree (one register per level) feeding a frame
//            accumulator; optional clamping via ADDER_TREE_ACC_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module adder_tree_acc #(
  parameter int SIZE     = 10,
  parameter int NUM      = 16,
  parameter int SIGNED   = 0,
  parameter int ACC_SIZE = 32,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                din_valid,
  input  logic                din_last,
  input  logic [SIZE-1:0]     din [0:NUM-1],
  output logic                dout_valid,
  output logic [ACC_SIZE-1:0] dout,
  output logic [CNT_W-1:0]    dout_beats,
  output logic                dout_ovf
);

  function automatic int level_cnt(input int lvl);
    return (NUM + (1 << lvl) - 1) >> lvl;
  endfunction

  function automatic int level_off(input int lvl);
    int s;
    s = 0;
    for (int k = 0; k < lvl; k++) s += level_cnt(k);
    return s;
  endfunction

  localparam int c_LAT   = (NUM < 2) ? 1 : $clog2(NUM);
  localparam int c_TW    = SIZE + $clog2(NUM);
  localparam int c_TOTAL = level_off(c_LAT + 1);

  if (ACC_SIZE < c_TW) begin : g_bad_acc_size
    $error("adder_tree_acc: ACC_SIZE must be >= SIZE+clog2(NUM)");
  end

  // All tree nodes carried at the final width; level l values fit in SIZE+l bits.
  logic [c_TW-1:0] w_node [0:c_TOTAL-1];

  genvar gi, gl;
  for (gi = 0; gi < NUM; gi++) begin : g_in
    if (SIGNED != 0) begin : g_sext
      assign w_node[gi] = c_TW'($signed(din[gi]));
    end else begin : g_zext
      assign w_node[gi] = c_TW'(din[gi]);
    end
  end

  for (gl = 1; gl <= c_LAT; gl++) begin : g_lvl
    localparam int c_PREV = level_cnt(gl - 1);
    localparam int c_CUR  = level_cnt(gl);
    localparam int c_PO   = level_off(gl - 1);
    localparam int c_CO   = level_off(gl);
    for (gi = 0; gi < c_CUR; gi++) begin : g_node
      logic [c_TW-1:0] r_sum;
      if (2 * gi + 1 < c_PREV) begin : g_add
        always_ff @(posedge clk) r_sum <= w_node[c_PO+2*gi] + w_node[c_PO+2*gi+1];
      end else begin : g_pass
        always_ff @(posedge clk) r_sum <= w_node[c_PO+2*gi];
      end
      assign w_node[c_CO+gi] = r_sum;
    end
  end

  logic [c_LAT-1:0] r_vld;
  logic [c_LAT-1:0] r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_vld <= '0;
    else     r_vld <= c_LAT'({r_vld, din_valid});
  end

  always_ff @(posedge clk) r_last <= c_LAT'({r_last, din_valid & din_last});

  logic                w_tv, w_tl;
  logic [c_TW-1:0]     w_tree;
  logic [ACC_SIZE-1:0] w_ext;

  assign w_tv   = r_vld[c_LAT-1];
  assign w_tl   = r_last[c_LAT-1];
  assign w_tree = w_node[c_TOTAL-1];

  if (SIGNED != 0) begin : g_acc_sext
    assign w_ext = ACC_SIZE'($signed(w_tree));
  end else begin : g_acc_zext
    assign w_ext = ACC_SIZE'(w_tree);
  end

  logic                r_first;
  logic [ACC_SIZE-1:0] r_acc;
  logic [CNT_W-1:0]    r_beats;
  logic                r_ovf;

  logic [ACC_SIZE-1:0] w_base, w_raw, w_acc_next;
  logic                w_carry, w_ovf_now, w_ovf_next;
  logic [CNT_W-1:0]    w_beats_next;

`ifdef ADDER_TREE_ACC_SAT_EN
  localparam logic [ACC_SIZE-1:0] c_SMAX = {1'b0, {(ACC_SIZE-1){1'b1}}};
  localparam logic [ACC_SIZE-1:0] c_SMIN = {1'b1, {(ACC_SIZE-1){1'b0}}};
`endif

  always_comb begin
    w_base             = r_first ? '0 : r_acc;
    {w_carry, w_raw}   = {1'b0, w_base} + {1'b0, w_ext};
    if (SIGNED != 0)
      w_ovf_now = (w_base[ACC_SIZE-1] == w_ext[ACC_SIZE-1]) &&
                  (w_raw[ACC_SIZE-1] != w_base[ACC_SIZE-1]);
    else
      w_ovf_now = w_carry;
`ifdef ADDER_TREE_ACC_SAT_EN
    // Clamp toward the shared operand sign; later beats continue from the clamp.
    if (!w_ovf_now)        w_acc_next = w_raw;
    else if (SIGNED == 0)  w_acc_next = '1;
    else                   w_acc_next = w_base[ACC_SIZE-1] ? c_SMIN : c_SMAX;
`else
    w_acc_next = w_raw;
`endif
    w_ovf_next   = (~r_first & r_ovf) | w_ovf_now;
    w_beats_next = r_first ? CNT_W'(1) : ((&r_beats) ? r_beats : r_beats + 1'b1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_first    <= 1'b1;
      r_acc      <= '0;
      r_beats    <= '0;
      r_ovf      <= 1'b0;
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_beats <= '0;
      dout_ovf   <= 1'b0;
    end else begin
      dout_valid <= w_tv & w_tl;
      if (w_tv) begin
        r_acc   <= w_acc_next;
        r_beats <= w_beats_next;
        r_ovf   <= w_ovf_next;
        r_first <= w_tl;
      end
      if (w_tv & w_tl) begin
        dout       <= w_acc_next;
        dout_beats <= w_beats_next;
        dout_ovf   <= w_ovf_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_tree_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_tree_acc
// Brief    : Directed bench for adder_tree_acc: unsigned/16, unsigned/10 and
//            signed/16 instances sharing one stimulus stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_tree_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       din_valid, din_last;
  logic [7:0] din [0:3];

  logic        a_dv, b_dv, c_dv;
  logic [15:0] a_dout, c_dout;
  logic [9:0]  b_dout;
  logic [15:0] a_beats, b_beats, c_beats;
  logic        a_ovf, b_ovf, c_ovf;

  int checks   = 0;
  int failures = 0;

  adder_tree_acc #(.SIZE(8), .NUM(4), .SIGNED(0), .ACC_SIZE(16), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_last(din_last), .din(din),
    .dout_valid(a_dv), .dout(a_dout), .dout_beats(a_beats), .dout_ovf(a_ovf));

  adder_tree_acc #(.SIZE(8), .NUM(4), .SIGNED(0), .ACC_SIZE(10), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_last(din_last), .din(din),
    .dout_valid(b_dv), .dout(b_dout), .dout_beats(b_beats), .dout_ovf(b_ovf));

  adder_tree_acc #(.SIZE(8), .NUM(4), .SIGNED(1), .ACC_SIZE(16), .CNT_W(16)) u_dut_c (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_last(din_last), .din(din),
    .dout_valid(c_dv), .dout(c_dout), .dout_beats(c_beats), .dout_ovf(c_ovf));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic l,
                     input logic [7:0] w0, input logic [7:0] w1,
                     input logic [7:0] w2, input logic [7:0] w3);
    din_valid = v;
    din_last  = l;
    din[0] = w0; din[1] = w1; din[2] = w2; din[3] = w3;
  endtask

  task automatic idle();
    put(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    checks++; if (a_dv !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", a_dv); end
    checks++; if (a_dout !== 16'd0) begin failures++; $display("FAIL reset_dout got=%0d exp=0", a_dout); end
    checks++; if (a_beats !== 16'd0) begin failures++; $display("FAIL reset_beats got=%0d exp=0", a_beats); end
    checks++; if (a_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", a_ovf); end
    #3 rst = 1'b0;
    tick();
  endtask

  task automatic test_single_beat();
    put(1'b1, 1'b1, 8'd1, 8'd2, 8'd3, 8'd4);
    tick();
    idle();
    tick();
    checks++; if (a_dv !== 1'b0) begin failures++; $display("FAIL single_early got=%0b exp=0", a_dv); end
    tick();
    checks++; if (a_dv !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", a_dv); end
    checks++; if (a_dout !== 16'd10) begin failures++; $display("FAIL single_dout got=%0d exp=10", a_dout); end
    checks++; if (a_beats !== 16'd1) begin failures++; $display("FAIL single_beats got=%0d exp=1", a_beats); end
    checks++; if (a_ovf !== 1'b0) begin failures++; $display("FAIL single_ovf got=%0b exp=0", a_ovf); end
    tick();
    checks++; if (a_dv !== 1'b0) begin failures++; $display("FAIL single_pulse_width got=%0b exp=0", a_dv); end
    checks++; if (a_dout !== 16'd10) begin failures++; $display("FAIL single_hold got=%0d exp=10", a_dout); end
  endtask

  task automatic test_gap_frame();
    int pulses, pk;
    logic [15:0] cd, cb;
    logic co;
    pulses = 0; pk = 0; cd = '0; cb = '0; co = 1'b0;
    put(1'b1, 1'b0, 8'd255, 8'd255, 8'd255, 8'd255);
    tick();
    idle();
    tick();
    tick();
    put(1'b1, 1'b0, 8'd255, 8'd255, 8'd255, 8'd255);
    tick();
    put(1'b1, 1'b1, 8'd255, 8'd255, 8'd255, 8'd255);
    tick();
    idle();
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (a_dv === 1'b1) begin
        pulses++; pk = k; cd = a_dout; cb = a_beats; co = a_ovf;
      end
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL gap_pulses got=%0d exp=1", pulses); end
    checks++; if (pk != 2) begin failures++; $display("FAIL gap_latency got=%0d exp=2", pk); end
    checks++; if (cd !== 16'd3060) begin failures++; $display("FAIL gap_dout got=%0d exp=3060", cd); end
    checks++; if (cb !== 16'd3) begin failures++; $display("FAIL gap_beats got=%0d exp=3", cb); end
    checks++; if (co !== 1'b0) begin failures++; $display("FAIL gap_ovf got=%0b exp=0", co); end
  endtask

  task automatic test_back_to_back();
    put(1'b1, 1'b1, 8'd1, 8'd1, 8'd1, 8'd1);
    tick();
    put(1'b1, 1'b1, 8'd2, 8'd2, 8'd2, 8'd2);
    tick();
    idle();
    tick();
    checks++; if (a_dv !== 1'b1) begin failures++; $display("FAIL b2b_valid0 got=%0b exp=1", a_dv); end
    checks++; if (a_dout !== 16'd4) begin failures++; $display("FAIL b2b_dout0 got=%0d exp=4", a_dout); end
    tick();
    checks++; if (a_dv !== 1'b1) begin failures++; $display("FAIL b2b_valid1 got=%0b exp=1", a_dv); end
    checks++; if (a_dout !== 16'd8) begin failures++; $display("FAIL b2b_dout1 got=%0d exp=8", a_dout); end
    checks++; if (a_beats !== 16'd1) begin failures++; $display("FAIL b2b_beats got=%0d exp=1", a_beats); end
    tick();
    checks++; if (a_dv !== 1'b0) begin failures++; $display("FAIL b2b_end got=%0b exp=0", a_dv); end
  endtask

  task automatic test_overflow();
    int pulses;
    logic [9:0]  bd, exp_bd;
    logic [15:0] bb, ad;
    logic        bo, ao;
    pulses = 0; bd = '0; bb = '0; bo = 1'b0; ad = '0; ao = 1'b1;
`ifdef ADDER_TREE_ACC_SAT_EN
    exp_bd = 10'd1023;
`else
    exp_bd = 10'd1016;
`endif
    put(1'b1, 1'b0, 8'd255, 8'd255, 8'd255, 8'd255);
    tick();
    put(1'b1, 1'b1, 8'd255, 8'd255, 8'd255, 8'd255);
    tick();
    idle();
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (b_dv === 1'b1) begin
        pulses++; bd = b_dout; bb = b_beats; bo = b_ovf; ad = a_dout; ao = a_ovf;
      end
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL ovf_pulses got=%0d exp=1", pulses); end
    checks++; if (bd !== exp_bd) begin failures++; $display("FAIL ovf_dout got=%0d exp=%0d", bd, exp_bd); end
    checks++; if (bo !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", bo); end
    checks++; if (bb !== 16'd2) begin failures++; $display("FAIL ovf_beats got=%0d exp=2", bb); end
    checks++; if (ad !== 16'd2040) begin failures++; $display("FAIL wide_dout got=%0d exp=2040", ad); end
    checks++; if (ao !== 1'b0) begin failures++; $display("FAIL wide_ovf got=%0b exp=0", ao); end
  endtask

  task automatic test_signed();
    put(1'b1, 1'b1, 8'h80, 8'h80, 8'h7F, 8'h01);
    tick();
    idle();
    tick();
    tick();
    checks++; if (c_dv !== 1'b1) begin failures++; $display("FAIL signed_valid got=%0b exp=1", c_dv); end
    checks++; if (c_dout !== 16'hFF80) begin failures++; $display("FAIL signed_dout got=%h exp=ff80", c_dout); end
    checks++; if (c_ovf !== 1'b0) begin failures++; $display("FAIL signed_ovf got=%0b exp=0", c_ovf); end
    checks++; if (a_dout !== 16'd384) begin failures++; $display("FAIL unsigned_view got=%0d exp=384", a_dout); end
  endtask

  task automatic test_reset_mid_frame();
    int pulses, pk;
    logic [15:0] cd, cb;
    pulses = 0; pk = 0; cd = '0; cb = '0;
    put(1'b1, 1'b0, 8'd9, 8'd9, 8'd9, 8'd9);
    tick();
    tick();
    put(1'b1, 1'b0, 8'd7, 8'd7, 8'd7, 8'd7);
    #3 rst = 1'b1;
    #1;
    checks++; if (a_dout !== 16'd0) begin failures++; $display("FAIL async_dout got=%0d exp=0", a_dout); end
    checks++; if (a_beats !== 16'd0) begin failures++; $display("FAIL async_beats got=%0d exp=0", a_beats); end
    checks++; if (a_dv !== 1'b0) begin failures++; $display("FAIL async_valid got=%0b exp=0", a_dv); end
    checks++; if (a_ovf !== 1'b0) begin failures++; $display("FAIL async_ovf got=%0b exp=0", a_ovf); end
    tick();
    tick();
    checks++; if (a_dout !== 16'd0) begin failures++; $display("FAIL held_rst_dout got=%0d exp=0", a_dout); end
    #3;
    rst = 1'b0;
    put(1'b1, 1'b1, 8'd1, 8'd2, 8'd3, 8'd4);
    tick();
    idle();
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (a_dv === 1'b1) begin
        pulses++; pk = k; cd = a_dout; cb = a_beats;
      end
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL rst_frame_pulses got=%0d exp=1", pulses); end
    checks++; if (pk != 2) begin failures++; $display("FAIL rst_frame_latency got=%0d exp=2", pk); end
    checks++; if (cd !== 16'd10) begin failures++; $display("FAIL rst_frame_dout got=%0d exp=10", cd); end
    checks++; if (cb !== 16'd1) begin failures++; $display("FAIL rst_frame_beats got=%0d exp=1", cb); end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_gap_frame();
    test_back_to_back();
    test_overflow();
    test_signed();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
